// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, done in the 33rd cycle after start (1 cycle for div-by-zero/overflow).
// No queuing: start is only sampled while idle, so the requester holds it until busy falls; flush aborts with no writeback.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic              reg_write,
    output logic [4:0]        rd_out,
    output logic [XLEN-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_pend_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   result_q;
    logic              busy_q;
    logic              done_q;

    // Operand decode at accept time
    logic              a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, shortcut;
    logic [XLEN-1:0]   short_res;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (funct3[2]) begin
            a_sgn = !funct3[0];
            b_sgn = !funct3[0];
        end else begin
            a_sgn = (funct3 != 3'd3);
            b_sgn = (funct3[1] == 1'b0);
        end
        a_neg  = a_sgn & rs1_data[XLEN-1];
        b_neg  = b_sgn & rs2_data[XLEN-1];
        a_mag  = a_neg ? -rs1_data : rs1_data;
        b_mag  = b_neg ? -rs2_data : rs2_data;
        // Remainder takes the dividend's sign; everything else the XOR of both
        neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero  = funct3[2] && (rs2_data == '0);
        div_ovf   = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
        shortcut  = div_zero || div_ovf;
        short_res = '0;
        if (div_zero) begin
            short_res = funct3[1] ? rs1_data : '1;
        end else if (div_ovf) begin
            short_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    // One iteration: hi/lo hold the partial product or remainder/quotient
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   hi_d, lo_d;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, opa_q});
        div_diff = div_sh[XLEN-1:0] - opa_q;
        if (op_q[2]) begin
            hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   div_res, div_s, fin_res;

    always_comb begin
        prod    = {hi_d, lo_d};
        prod_s  = neg_q ? -prod : prod;
        div_res = op_q[1] ? hi_d : lo_d;
        div_s   = neg_q ? -div_res : div_res;
        if (op_q[2]) begin
            fin_res = div_s;
        end else if (op_q[1:0] == 2'd0) begin
            fin_res = prod_s[XLEN-1:0];
        end else begin
            fin_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            opa_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            rd_pend_q <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !flush) begin
                        op_q      <= funct3;
                        neg_q     <= neg_in;
                        rd_pend_q <= rd_in;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        busy_q    <= 1'b1;
                        opa_q     <= funct3[2] ? b_mag : a_mag;
                        lo_q      <= funct3[2] ? a_mag : b_mag;
                        if (shortcut) begin
                            result_q <= short_res;
                            rd_q     <= rd_in;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            result_q <= fin_res;
                            rd_q     <= rd_pend_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing on the completion cycle suppresses the writeback strobe
    assign busy      = busy_q;
    assign done      = done_q && !flush;
    assign reg_write = done && (rd_q != 5'd0);
    assign rd_out    = rd_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit with a queue-based scoreboard and arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, reg_write;
    logic [4:0]  rd_out;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .rs1_data(rs1), .rs2_data(rs2), .rd_in(rd_in), .busy(busy), .done(done),
        .reg_write(reg_write), .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending op
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("rd_out", rd_out, e.rd);
                    chk("reg_write", reg_write, (e.rd != 0));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else begin
                chk("rw_without_done", reg_write, 0);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expect_done);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            exp_t e;
            e.res = model(f, a, b);
            e.rd  = rd;
            e.cyc = cyc + latency(f, a, b) - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 1, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d ops pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_rd_out", rd_out, 0);
        reset = 1'b1;

        // Directed vectors
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1); wait_idle();
        chk("mul_hold", result, 32'hFFFF_FFEB);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1); wait_idle();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1); wait_idle();
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1); wait_idle();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1); wait_idle();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1); wait_idle();
        issue(3'd5, 32'd100, 32'd7, 5'd7, 1); wait_idle();
        issue(3'd7, 32'd100, 32'd7, 5'd8, 1); wait_idle();
        issue(3'd5, 32'd100, 32'd0, 5'd9, 1); wait_idle();
        issue(3'd7, 32'd100, 32'd0, 5'd10, 1); wait_idle();
        chk("remu0_hold", result, 32'd100);
        issue(3'd4, MIN, 32'hFFFF_FFFF, 5'd11, 1); wait_idle();
        issue(3'd6, MIN, 32'hFFFF_FFFF, 5'd12, 1); wait_idle();
        issue(3'd0, 32'd3, 32'd3, 5'd0, 1); wait_idle();

        // start re-asserted mid-run must be ignored
        issue(3'd5, 32'd1000, 32'd9, 5'd13, 1);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5; rd_in = 5'd14;
        @(posedge clk); #1; start = 1'b0;
        wait_idle();

        // flush in RUN
        issue(3'd0, 32'd1234, 32'd5678, 5'd15, 0);
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        repeat (40) @(negedge clk);

        // flush on the completion cycle
        issue(3'd1, 32'd77, 32'd88, 5'd16, 0);
        repeat (32) @(posedge clk);
        #1; flush = 1'b1;
        @(negedge clk);
        chk("flushdone_done", done, 0);
        chk("flushdone_busy", busy, 1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flushdone_idle", busy, 0);

        // start together with flush while idle is not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'd4; rs2 = 32'd0; rd_in = 5'd17;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("startflush_busy", busy, 0);
        repeat (3) @(negedge clk);

        // reset mid-operation
        issue(3'd4, 32'd999, 32'd3, 5'd18, 0);
        repeat (9) @(posedge clk);
        #1; reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rw", reg_write, 0);
        chk("midrst_rd", rd_out, 0);
        chk("midrst_result", result, 0);
        @(negedge clk); reset = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1);
            wait_idle();
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_at_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
